sram_req_arbiter: RTL and testbench

- Shares one SRAM-like memory port between two requesters: instruction fetch (read-only) and the EX/MEM data access path.
- Sits between the pipeline stages and the memory bridge.
- Grants one request per handshake and holds the grant stable until accepted.
- Tracks outstanding requests in order, so each `mem_data_ok` / `mem_rdata` is routed back to the requester that issued it.

---
 rtl/sram_req_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_sram_req_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_arbiter.sv
// Two-requester (fetch / data) arbiter onto one SRAM-like port with in-order response routing.
// Optional accept counters are built when SRAM_ARB_PERF_EN is defined.
module sram_req_arbiter #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,
    output logic [31:0] perf_inst_cnt,
    output logic [31:0] perf_data_cnt
);

    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STV_W-1:0] STV_MAX = STV_W'(STARVE_LIMIT);

    typedef enum logic { OWN_INST = 1'b0, OWN_DATA = 1'b1 } owner_t;

    // Storage is always 4 deep; pointers wrap at MAX_OUTSTANDING so only that many are used.
    logic [3:0]       fifo;
    logic [1:0]       wr_ptr;
    logic [1:0]       rd_ptr;
    logic [2:0]       count;
    logic             lock;
    owner_t           lock_id;
    logic [STV_W-1:0] starve;

    owner_t grant;
    owner_t head;
    logic   full;
    logic   accept;
    logic   pop;

    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        if (p == 2'(MAX_OUTSTANDING - 1)) begin
            return 2'd0;
        end else begin
            return p + 2'd1;
        end
    endfunction

    assign full   = (count == 3'(MAX_OUTSTANDING));
    assign head   = owner_t'(fifo[rd_ptr]);
    assign accept = mem_req & mem_addr_ok;
    assign pop    = !reset & mem_data_ok & (count != 3'd0);

    // Grant selection: a held request keeps its owner until memory takes it.
    always_comb begin
        grant = OWN_INST;
        if (lock) begin
            grant = lock_id;
        end else if (inst_req && (!data_req || starve == STV_MAX)) begin
            grant = OWN_INST;
        end else if (data_req) begin
            grant = OWN_DATA;
        end else begin
            grant = OWN_INST;
        end
    end

    // Request path and field mux toward memory, all forced low during reset.
    always_comb begin
        mem_req   = !reset && !full && (lock || inst_req || data_req);
        mem_wr    = 1'b0;
        mem_size  = 2'd0;
        mem_wstrb = 4'd0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        if (!reset && grant == OWN_DATA) begin
            mem_wr    = data_wr;
            mem_size  = data_size;
            mem_wstrb = data_wstrb;
            mem_addr  = data_addr;
            mem_wdata = data_wdata;
        end else if (!reset) begin
            mem_size  = 2'd2;
            mem_addr  = inst_addr;
        end else begin
            mem_req   = 1'b0;
        end
    end

    assign inst_addr_ok = accept & (grant == OWN_INST);
    assign data_addr_ok = accept & (grant == OWN_DATA);
    assign inst_data_ok = pop & (head == OWN_INST);
    assign data_data_ok = pop & (head == OWN_DATA);
    assign inst_rdata   = reset ? 32'd0 : mem_rdata;
    assign data_rdata   = reset ? 32'd0 : mem_rdata;

    // Owner FIFO and occupancy; push and pop in one cycle leave count unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo   <= 4'd0;
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (accept) begin
                fifo[wr_ptr] <= grant;
                wr_ptr       <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({accept, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    // Lock and starvation tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock    <= 1'b0;
            lock_id <= OWN_INST;
            starve  <= '0;
        end else begin
            if (accept) begin
                lock <= 1'b0;
            end else if (mem_req) begin
                lock    <= 1'b1;
                lock_id <= grant;
            end else begin
                lock <= lock;
            end
            if (!inst_req || (accept && grant == OWN_INST)) begin
                starve <= '0;
            end else if (accept && starve != STV_MAX) begin
                starve <= starve + STV_W'(1);
            end else begin
                starve <= starve;
            end
        end
    end

`ifdef SRAM_ARB_PERF_EN
    // Accepted-request counters, wrapping naturally at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_inst_cnt <= 32'd0;
            perf_data_cnt <= 32'd0;
        end else begin
            if (inst_addr_ok) begin
                perf_inst_cnt <= perf_inst_cnt + 32'd1;
            end
            if (data_addr_ok) begin
                perf_data_cnt <= perf_data_cnt + 32'd1;
            end
        end
    end
`else
    assign perf_inst_cnt = 32'd0;
    assign perf_data_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter: expected response owners are queued on accept and
// popped when memory responds.
module tb_sram_req_arbiter;

    logic        clk;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;
    logic [31:0] perf_inst_cnt;
    logic [31:0] perf_data_cnt;

    int   checks   = 0;
    int   failures = 0;
    int   n_inst   = 0;
    int   n_data   = 0;
    logic sb[$];

    sram_req_arbiter #(.MAX_OUTSTANDING(2), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
        .perf_inst_cnt(perf_inst_cnt), .perf_data_cnt(perf_data_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        #2;
    endtask

    // Checks handshakes and response routing for the current cycle, then advances one clock.
    task automatic tick(input string tag, input logic e_i, input logic e_d);
        logic id;
        logic exp_iok;
        logic exp_dok;
        exp_iok = 1'b0;
        exp_dok = 1'b0;
        if (mem_data_ok && sb.size() > 0) begin
            id      = sb.pop_front();
            exp_iok = (id == 1'b0);
            exp_dok = (id == 1'b1);
        end
        chk({tag, ".inst_addr_ok"}, {31'd0, inst_addr_ok}, {31'd0, e_i});
        chk({tag, ".data_addr_ok"}, {31'd0, data_addr_ok}, {31'd0, e_d});
        chk({tag, ".inst_data_ok"}, {31'd0, inst_data_ok}, {31'd0, exp_iok});
        chk({tag, ".data_data_ok"}, {31'd0, data_data_ok}, {31'd0, exp_dok});
        chk({tag, ".inst_rdata"}, inst_rdata, mem_rdata);
        chk({tag, ".data_rdata"}, data_rdata, mem_rdata);
`ifdef SRAM_ARB_PERF_EN
        chk({tag, ".perf_inst"}, perf_inst_cnt, 32'(n_inst));
        chk({tag, ".perf_data"}, perf_data_cnt, 32'(n_data));
`else
        chk({tag, ".perf_inst"}, perf_inst_cnt, 32'd0);
        chk({tag, ".perf_data"}, perf_data_cnt, 32'd0);
`endif
        if (e_i) begin
            sb.push_back(1'b0);
            n_inst++;
        end
        if (e_d) begin
            sb.push_back(1'b1);
            n_data++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".mem_req"}, {31'd0, mem_req}, 32'd0);
        chk({tag, ".mem_wr"}, {31'd0, mem_wr}, 32'd0);
        chk({tag, ".mem_size"}, {30'd0, mem_size}, 32'd0);
        chk({tag, ".mem_wstrb"}, {28'd0, mem_wstrb}, 32'd0);
        chk({tag, ".mem_addr"}, mem_addr, 32'd0);
        chk({tag, ".mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, ".inst_addr_ok"}, {31'd0, inst_addr_ok}, 32'd0);
        chk({tag, ".inst_data_ok"}, {31'd0, inst_data_ok}, 32'd0);
        chk({tag, ".inst_rdata"}, inst_rdata, 32'd0);
        chk({tag, ".data_addr_ok"}, {31'd0, data_addr_ok}, 32'd0);
        chk({tag, ".data_data_ok"}, {31'd0, data_data_ok}, 32'd0);
        chk({tag, ".data_rdata"}, data_rdata, 32'd0);
        chk({tag, ".perf_inst"}, perf_inst_cnt, 32'd0);
        chk({tag, ".perf_data"}, perf_data_cnt, 32'd0);
    endtask

    task automatic set_data(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        data_req   = 1'b1;
        data_wr    = wr;
        data_size  = 2'd2;
        data_wstrb = wr ? 4'hF : 4'h0;
        data_addr  = addr;
        data_wdata = wdata;
    endtask

    task automatic drain(input string tag);
        inst_req    = 1'b0;
        data_req    = 1'b0;
        mem_addr_ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (sb.size() > 0) begin
                mem_data_ok = 1'b1;
                mem_rdata   = $urandom;
                settle();
                tick(tag, 1'b0, 1'b0);
            end
        end
        mem_data_ok = 1'b0;
    endtask

    initial begin
        logic [5:0] pat;
        reset       = 1'b1;
        inst_req    = 1'b1;
        inst_addr   = 32'h1C00_0000;
        set_data(1'b1, 32'h0000_0040, 32'h1111_2222);
        mem_addr_ok = 1'b1;
        mem_data_ok = 1'b1;
        mem_rdata   = 32'hFFFF_FFFF;
        #3;
        check_all_zero("rst_init");
        @(posedge clk);
        #1;
        reset       = 1'b0;
        data_req    = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata   = 32'd0;

        // Single fetch and its response.
        inst_req = 1'b1; inst_addr = 32'h1C00_0000; mem_addr_ok = 1'b1;
        settle();
        chk("t1.mem_req", {31'd0, mem_req}, 32'd1);
        chk("t1.mem_addr", mem_addr, 32'h1C00_0000);
        chk("t1.mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("t1.mem_size", {30'd0, mem_size}, 32'd2);
        tick("t1.req", 1'b1, 1'b0);
        inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h1234_5678;
        settle();
        chk("t1.mem_req_idle", {31'd0, mem_req}, 32'd0);
        chk("t1.inst_rdata_val", inst_rdata, 32'h1234_5678);
        tick("t1.resp", 1'b0, 1'b0);

        // Both request: data wins when the starve count is clear.
        mem_data_ok = 1'b0;
        inst_req = 1'b1; inst_addr = 32'h1C00_0004;
        set_data(1'b1, 32'h0000_0080, 32'hDEAD_BEEF);
        mem_addr_ok = 1'b1;
        settle();
        chk("t2.mem_wr", {31'd0, mem_wr}, 32'd1);
        chk("t2.mem_addr", mem_addr, 32'h0000_0080);
        chk("t2.mem_wstrb", {28'd0, mem_wstrb}, 32'hF);
        chk("t2.mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        tick("t2", 1'b0, 1'b1);

        // Data held for three cycles; inst arriving meanwhile must not steal the port.
        inst_req = 1'b0; set_data(1'b0, 32'h0000_0080, 32'd0);
        mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h0000_0055;
        settle();
        chk("t3.c0.mem_addr", mem_addr, 32'h0000_0080);
        tick("t3.c0", 1'b0, 1'b0);
        mem_data_ok = 1'b0; inst_req = 1'b1; inst_addr = 32'h1C00_0008;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("t3.hold.mem_addr", mem_addr, 32'h0000_0080);
            chk("t3.hold.mem_req", {31'd0, mem_req}, 32'd1);
            tick("t3.hold", 1'b0, 1'b0);
        end
        mem_addr_ok = 1'b1;
        settle();
        chk("t3.acc.mem_addr", mem_addr, 32'h0000_0080);
        tick("t3.acc", 1'b0, 1'b1);

        // Inst locks; a data request arriving later must wait although data would otherwise win.
        data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h0000_0077;
        settle();
        tick("lk.c0", 1'b0, 1'b0);
        mem_data_ok = 1'b0; set_data(1'b1, 32'h0000_0090, 32'hAAAA_5555);
        settle();
        chk("lk.c1.mem_addr", mem_addr, 32'h1C00_0008);
        chk("lk.c1.mem_wr", {31'd0, mem_wr}, 32'd0);
        tick("lk.c1", 1'b0, 1'b0);
        mem_addr_ok = 1'b1;
        settle();
        tick("lk.acc", 1'b1, 1'b0);

        // Data then inst back to back; then full blocks requests until a response.
        inst_addr = 32'h1C00_000C; mem_data_ok = 1'b1; mem_rdata = 32'h0000_0099;
        settle();
        tick("t4.data", 1'b0, 1'b1);
        data_req = 1'b0; mem_data_ok = 1'b0;
        settle();
        tick("t4.inst", 1'b1, 1'b0);
        data_req = 1'b1;
        settle();
        chk("t6.full.mem_req", {31'd0, mem_req}, 32'd0);
        tick("t6.full", 1'b0, 1'b0);
        mem_data_ok = 1'b1; mem_rdata = 32'h0000_000A;
        settle();
        chk("t6.full_pop.mem_req", {31'd0, mem_req}, 32'd0);
        tick("t4.resp_a", 1'b0, 1'b0);
        inst_req = 1'b0; data_req = 1'b0; mem_rdata = 32'h0000_000B;
        settle();
        tick("t4.resp_b", 1'b0, 1'b0);
        mem_data_ok = 1'b0;

        // Starvation: four data grants, then inst, then data again.
        pat = 6'b010000;
        for (int k = 0; k < 6; k++) begin
            inst_req = 1'b1; inst_addr = 32'h1C00_0010;
            set_data(1'b0, 32'h0000_0100 + 32'(k) * 32'd4, 32'd0);
            mem_addr_ok = 1'b1;
            mem_data_ok = (sb.size() > 0);
            mem_rdata   = $urandom;
            settle();
            chk("t5.mem_req", {31'd0, mem_req}, 32'd1);
            chk("t5.mem_addr", mem_addr, pat[k] ? 32'h1C00_0010 : 32'h0000_0100 + 32'(k) * 32'd4);
            tick("t5", pat[k], !pat[k]);
        end
        drain("t5.drain");

        // Fill, then asynchronous reset mid-cycle.
        inst_req = 1'b1; mem_addr_ok = 1'b1;
        settle();
        tick("r.i", 1'b1, 1'b0);
        inst_req = 1'b0; set_data(1'b1, 32'h0000_0200, 32'h0BAD_F00D);
        settle();
        tick("r.d", 1'b0, 1'b1);
        inst_req = 1'b1;
        settle();
        chk("r.full.mem_req", {31'd0, mem_req}, 32'd0);
        tick("r.full", 1'b0, 1'b0);
        mem_data_ok = 1'b1; mem_rdata = 32'hCAFE_F00D;
        #1;
        reset = 1'b1;
        #1;
        check_all_zero("rst_mid");
        sb.delete();
        n_inst = 0;
        n_data = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // After reset: stray response ignored, count is zero so requests flow again.
        inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0;
        settle();
        tick("pr.stray", 1'b0, 1'b0);
        mem_data_ok = 1'b0; inst_req = 1'b1; set_data(1'b0, 32'h0000_0300, 32'd0);
        mem_addr_ok = 1'b1;
        settle();
        chk("pr.mem_req", {31'd0, mem_req}, 32'd1);
        tick("pr.d", 1'b0, 1'b1);
        data_req = 1'b0;
        settle();
        tick("pr.i", 1'b1, 1'b0);
        data_req = 1'b1;
        settle();
        chk("pr.full.mem_req", {31'd0, mem_req}, 32'd0);
        tick("pr.full", 1'b0, 1'b0);
        drain("pr.drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
